map_table_checkpoint_ctrl: RTL and testbench

MAP_TABLE_CHECKPOINT_CTRL -- requirements
Module: map_table_checkpoint_ctrl

---
 rtl/core_types_pkg.sv | 22 ++
 rtl/map_table_checkpoint_ctrl.sv | 134 +++++++++++++
 tb/tb_map_table_checkpoint_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: map table geometry, checkpoint queue sizing and the
// checkpoint controller FSM state encoding.
package core_types_pkg;

  // Architectural registers and physical register tag width.
  localparam int AR_COUNT             = 8;
  localparam int LOG_PR_COUNT         = 6;

  // Number of map table snapshot slots and its log2.
  localparam int CHECKPOINT_COUNT     = 8;
  localparam int LOG_CHECKPOINT_COUNT = 3;

  // One complete map table: a physical tag per architectural register.
  typedef logic [AR_COUNT-1:0][LOG_PR_COUNT-1:0] map_table_t;

  // Checkpoint controller states.
  typedef enum logic {
    CKPT_IDLE    = 1'b0,
    CKPT_RESTORE = 1'b1
  } ckpt_state_e;

endpackage

// File: rtl/map_table_checkpoint_ctrl.sv
// Map table checkpoint controller: a circular queue of map table snapshots.
// Saves append at the tail, frees retire the head, and a restore rolls the
// tail back to a chosen checkpoint while replaying its snapshot for one cycle.
module map_table_checkpoint_ctrl #(
  parameter int CHECKPOINT_COUNT     = core_types_pkg::CHECKPOINT_COUNT,
  parameter int LOG_CHECKPOINT_COUNT = core_types_pkg::LOG_CHECKPOINT_COUNT
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            save_valid,
  input  core_types_pkg::map_table_t      save_map_table,
  output logic                            save_ready,
  output logic [LOG_CHECKPOINT_COUNT-1:0] save_index,
  input  logic                            restore_req_valid,
  input  logic [LOG_CHECKPOINT_COUNT-1:0] restore_req_index,
  input  logic                            free_valid,
  input  logic                            flush_valid,
  output logic                            restore_valid,
  output core_types_pkg::map_table_t      restore_map_table,
  output logic [LOG_CHECKPOINT_COUNT:0]   occupancy
);
  import core_types_pkg::*;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = LOG_CHECKPOINT_COUNT + 1;
  typedef logic [PW-1:0] ptr_t;

  ptr_t        head_q, head_d;
  ptr_t        tail_q, tail_d;
  ckpt_state_e state_q, state_d;
  map_table_t  restore_map_table_q, restore_map_table_d;
  map_table_t  slots_q [CHECKPOINT_COUNT];
  map_table_t  slots_d [CHECKPOINT_COUNT];

  logic [LOG_CHECKPOINT_COUNT-1:0] head_idx;
  logic [LOG_CHECKPOINT_COUNT-1:0] tail_idx;
  logic [LOG_CHECKPOINT_COUNT-1:0] restore_offset;
  ptr_t                            live_count;
  logic                            full;
  logic                            empty;
  logic                            save_fire;
  logic                            restore_legal;
  logic                            free_fire;

  assign head_idx   = head_q[LOG_CHECKPOINT_COUNT-1:0];
  assign tail_idx   = tail_q[LOG_CHECKPOINT_COUNT-1:0];
  assign live_count = tail_q - head_q;
  assign empty      = (head_q == tail_q);
  assign full       = (head_idx == tail_idx) &&
                      (head_q[LOG_CHECKPOINT_COUNT] != tail_q[LOG_CHECKPOINT_COUNT]);

  // Age of the requested checkpoint relative to the oldest live one; the
  // request is live exactly when that age is below the live count.
  assign restore_offset = restore_req_index - head_idx;

  assign save_ready    = !full && (state_q == CKPT_IDLE) && !restore_req_valid && !flush_valid;
  assign save_fire     = save_valid && save_ready;
  assign restore_legal = restore_req_valid && !flush_valid && (state_q == CKPT_IDLE) &&
                         ({1'b0, restore_offset} < live_count);
  assign free_fire     = free_valid && !empty && !flush_valid;

  assign save_index        = tail_idx;
  assign occupancy         = live_count;
  assign restore_valid     = (state_q == CKPT_RESTORE);
  assign restore_map_table = restore_map_table_q;

  // Next-state logic for pointers, FSM and the replayed snapshot.
  always_comb begin
    head_d              = head_q;
    tail_d              = tail_q;
    state_d             = state_q;
    restore_map_table_d = restore_map_table_q;

    case (state_q)
      CKPT_IDLE:    if (restore_legal) state_d = CKPT_RESTORE;
      CKPT_RESTORE: state_d = CKPT_IDLE;
      default:      state_d = CKPT_IDLE;
    endcase

    if (save_fire) begin
      tail_d = tail_q + ptr_t'(1);
    end

    if (restore_legal) begin
      restore_map_table_d = slots_q[restore_req_index];
      // Rolling back to the head while it is also being freed empties the
      // queue; the tail must then follow the advanced head, not trail it.
      if (free_fire && (restore_offset == '0)) begin
        tail_d = head_q + ptr_t'(1);
      end else begin
        tail_d = head_q + {1'b0, restore_offset};
      end
    end

    if (free_fire) begin
      head_d = head_q + ptr_t'(1);
    end

    if (flush_valid) begin
      head_d  = '0;
      tail_d  = '0;
      state_d = CKPT_IDLE;
    end
  end

  // Slot write port: an accepted save lands in the current tail slot.
  always_comb begin
    slots_d = slots_q;
    if (save_fire) begin
      slots_d[tail_idx] = save_map_table;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q              <= '0;
      tail_q              <= '0;
      state_q             <= CKPT_IDLE;
      restore_map_table_q <= '0;
    end else begin
      head_q              <= head_d;
      tail_q              <= tail_d;
      state_q             <= state_d;
      restore_map_table_q <= restore_map_table_d;
    end
  end

  // Snapshot storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    slots_q <= slots_d;
  end

endmodule

// File: tb/tb_map_table_checkpoint_ctrl.sv
// Self-checking bench for map_table_checkpoint_ctrl: directed scenarios with
// literal expectations, then randomized traffic against a queue-level model.
module tb_map_table_checkpoint_ctrl;
  import core_types_pkg::*;

  localparam int N   = CHECKPOINT_COUNT;
  localparam int LOG = LOG_CHECKPOINT_COUNT;
  localparam int MW  = AR_COUNT * LOG_PR_COUNT;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             save_valid = 1'b0;
  map_table_t       save_map_table = '0;
  logic             save_ready;
  logic [LOG-1:0]   save_index;
  logic             restore_req_valid = 1'b0;
  logic [LOG-1:0]   restore_req_index = '0;
  logic             free_valid = 1'b0;
  logic             flush_valid = 1'b0;
  logic             restore_valid;
  map_table_t       restore_map_table;
  logic [LOG:0]     occupancy;

  map_table_checkpoint_ctrl #(
    .CHECKPOINT_COUNT    (N),
    .LOG_CHECKPOINT_COUNT(LOG)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .save_valid       (save_valid),
    .save_map_table   (save_map_table),
    .save_ready       (save_ready),
    .save_index       (save_index),
    .restore_req_valid(restore_req_valid),
    .restore_req_index(restore_req_index),
    .free_valid       (free_valid),
    .flush_valid      (flush_valid),
    .restore_valid    (restore_valid),
    .restore_map_table(restore_map_table),
    .occupancy        (occupancy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: oldest slot plus a live count, snapshot memory,
  // and the pending replay.
  int         m_head = 0;
  int         m_count = 0;
  map_table_t m_mem [N];
  logic       m_rv = 1'b0;
  map_table_t m_rdata = '0;
  int         m_off;
  bit         m_legal, m_sfire, m_ffire;

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      m_head = 0; m_count = 0; m_rv = 1'b0; m_rdata = '0;
    end else if (flush_valid) begin
      m_head = 0; m_count = 0; m_rv = 1'b0;
    end else begin
      m_sfire = save_valid && (m_count < N) && !m_rv && !restore_req_valid;
      m_off   = (int'(restore_req_index) - m_head + N) % N;
      m_legal = restore_req_valid && !m_rv && (m_off < m_count);
      m_ffire = free_valid && (m_count > 0);
      if (m_legal) m_rdata = m_mem[restore_req_index];
      m_rv = m_legal;
      if (m_sfire) begin
        m_mem[(m_head + m_count) % N] = save_map_table;
        m_count++;
      end
      if (m_legal) m_count = m_off;
      if (m_ffire) begin
        m_head  = (m_head + 1) % N;
        m_count = (m_count > 0) ? m_count - 1 : 0;
      end
    end
  end

  // Compare process: every falling edge outside reset.
  initial forever begin
    @(negedge CLK);
    if (chk_en && !RST) begin
      chk("cyc_save_ready", save_ready,
          ((m_count < N) && !m_rv && !restore_req_valid && !flush_valid) ? 1 : 0);
      chk("cyc_save_index", save_index, (m_head + m_count) % N);
      chk("cyc_occupancy", occupancy, m_count);
      chk("cyc_restore_valid", restore_valid, m_rv);
      chk("cyc_restore_map_table", restore_map_table, m_rdata);
    end
  end

  map_table_t snaps [N];

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic rand_snap(output map_table_t s);
    logic [63:0] r;
    r = {$urandom, $urandom};
    s = r[MW-1:0];
  endtask

  task automatic save(input int exp_idx);
    map_table_t d;
    rand_snap(d);
    snaps[exp_idx] = d;
    save_valid = 1'b1;
    save_map_table = d;
    #1;
    chk("save_index", save_index, exp_idx);
    chk("save_ready", save_ready, 1);
    tick();
    save_valid = 1'b0;
  endtask

  initial begin
    map_table_t d;
    tick();
    tick();
    RST = 1'b0;
    chk_en = 1'b1;

    // Reset state, then fill all slots.
    #1;
    chk("rst_occupancy", occupancy, 0);
    chk("rst_restore_valid", restore_valid, 0);
    chk("rst_restore_map_table", restore_map_table, 0);
    chk("rst_save_ready", save_ready, 1);
    for (int i = 0; i < N; i++) save(i);
    #1;
    chk("full_save_ready", save_ready, 0);
    chk("full_occupancy", occupancy, 8);

    // Wrap around: head=3, tail=3 with differing wrap bits.
    free_valid = 1'b1;
    tick(); tick(); tick();
    free_valid = 1'b0;
    for (int i = 0; i < 3; i++) save(i);
    #1;
    chk("wrap_full_occupancy", occupancy, 8);
    chk("wrap_full_save_ready", save_ready, 0);
    free_valid = 1'b1;
    tick();
    free_valid = 1'b0;
    #1;
    chk("wrap_free_occupancy", occupancy, 7);
    save(3);
    #1;
    chk("wrap_refill_occupancy", occupancy, 8);

    // Flush, save 0..4, restore checkpoint 2.
    flush_valid = 1'b1;
    tick();
    flush_valid = 1'b0;
    #1;
    chk("flush_occupancy", occupancy, 0);
    chk("flush_save_index", save_index, 0);
    for (int i = 0; i < 5; i++) save(i);
    restore_req_valid = 1'b1;
    restore_req_index = 3'd2;
    #1;
    chk("req_blocks_save", save_ready, 0);
    tick();
    restore_req_valid = 1'b0;
    #1;
    chk("rst2_restore_valid", restore_valid, 1);
    chk("rst2_restore_data", restore_map_table, snaps[2]);
    chk("rst2_occupancy", occupancy, 2);
    chk("rst2_save_ready_busy", save_ready, 0);
    tick();
    #1;
    chk("rst2_valid_drop", restore_valid, 0);
    chk("rst2_next_save_index", save_index, 2);
    chk("rst2_data_hold", restore_map_table, snaps[2]);

    // Unallocated index is ignored; flush during RESTORE cancels everything.
    restore_req_valid = 1'b1;
    restore_req_index = 3'd6;
    tick();
    restore_req_valid = 1'b0;
    #1;
    chk("illegal_restore_valid", restore_valid, 0);
    chk("illegal_occupancy", occupancy, 2);
    chk("illegal_save_index", save_index, 2);
    restore_req_valid = 1'b1;
    restore_req_index = 3'd1;
    tick();
    restore_req_valid = 1'b0;
    #1;
    chk("rst1_restore_valid", restore_valid, 1);
    chk("rst1_restore_data", restore_map_table, snaps[1]);
    flush_valid = 1'b1;
    tick();
    flush_valid = 1'b0;
    #1;
    chk("flush_busy_occupancy", occupancy, 0);
    chk("flush_busy_restore_valid", restore_valid, 0);
    chk("flush_busy_save_index", save_index, 0);

    // Restore to head while freeing head in the same cycle.
    for (int i = 0; i < 3; i++) save(i);
    free_valid = 1'b1;
    tick();
    free_valid = 1'b0;
    #1;
    chk("pre_headrst_occupancy", occupancy, 2);
    restore_req_valid = 1'b1;
    restore_req_index = 3'd1;
    free_valid = 1'b1;
    tick();
    restore_req_valid = 1'b0;
    free_valid = 1'b0;
    #1;
    chk("headrst_occupancy", occupancy, 0);
    chk("headrst_restore_valid", restore_valid, 1);
    chk("headrst_restore_data", restore_map_table, snaps[1]);
    chk("headrst_save_index", save_index, 2);
    tick();

    // Asynchronous reset in the middle of a RESTORE cycle.
    save(2);
    save(3);
    restore_req_valid = 1'b1;
    restore_req_index = 3'd2;
    tick();
    restore_req_valid = 1'b0;
    #1;
    chk("prereset_restore_valid", restore_valid, 1);
    RST = 1'b1;
    #1;
    chk("async_rst_restore_valid", restore_valid, 0);
    chk("async_rst_occupancy", occupancy, 0);
    chk("async_rst_restore_map_table", restore_map_table, 0);
    chk("async_rst_save_index", save_index, 0);
    #2;
    RST = 1'b0;
    tick();

    // Randomized traffic checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      rand_snap(d);
      save_valid        = ($urandom_range(0, 1) == 1);
      save_map_table    = d;
      restore_req_valid = ($urandom_range(0, 7) == 0);
      restore_req_index = LOG'($urandom_range(0, N - 1));
      free_valid        = ($urandom_range(0, 3) == 0);
      flush_valid       = ($urandom_range(0, 63) == 0);
      tick();
    end
    save_valid = 1'b0;
    restore_req_valid = 1'b0;
    free_valid = 1'b0;
    flush_valid = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
